// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch cache.
//   ifu_icache_state_t : refill sequencer states
//   ifu_tag_entry_t    : one tag-array entry (valid + tag). The tag field is
//                        sized for the widest possible tag; narrower tags are
//                        zero-extended.
//   sat_inc            : saturating increment for the statistics counters
package ifu_pkg;

   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_WAIT = 2'd2,
      FILL      = 2'd3
   } ifu_icache_state_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] tag;
   } ifu_tag_entry_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ifu_icache_if.sv
// Core-side fetch and memory-side refill signals of the instruction cache.
//   slave  : the cache
//   master : whoever drives fetch requests and answers refills
// Ports: pc/pcValid/pcReady (fetch request), insLineOut/insLineValidOut
// (returned line), memReq*/memRsp* (refill), flush, hitCount/missCount.
interface ifu_icache_if #(
   parameter int LINE_WIDTH = 128
);
   logic [31:0]           pc;
   logic                  pcValid;
   logic                  pcReady;
   logic [LINE_WIDTH-1:0] insLineOut;
   logic                  insLineValidOut;
   logic                  memReqValid;
   logic [31:0]           memReqAddr;
   logic                  memReqReady;
   logic                  memRspValid;
   logic [LINE_WIDTH-1:0] memRspLine;
   logic                  flush;
   logic [31:0]           hitCount;
   logic [31:0]           missCount;

   modport slave (
      input  pc, pcValid, memReqReady, memRspValid, memRspLine, flush,
      output pcReady, insLineOut, insLineValidOut, memReqValid, memReqAddr,
             hitCount, missCount
   );

   modport master (
      output pc, pcValid, memReqReady, memRspValid, memRspLine, flush,
      input  pcReady, insLineOut, insLineValidOut, memReqValid, memReqAddr,
             hitCount, missCount
   );
endinterface

// File: rtl/ifu_plru.sv
// Tree pseudo-LRU for one set, purely combinational.
//   tree_in    : current tree bits (node 0 = root, children of n at 2n+1/2n+2)
//   access_way : way being touched
//   tree_out   : tree after the touch; every node on the path points away
//   victim_way : way reached by following the pointers of tree_in
// A node bit of 1 points to its right (upper-index) subtree.
module ifu_plru #(
   parameter  int NUM_WAYS = 4,
   localparam int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-2:0] tree_in,
   input  logic [WAY_W-1:0]    access_way,
   output logic [NUM_WAYS-2:0] tree_out,
   output logic [WAY_W-1:0]    victim_way
);

   int   upd_node;
   int   vic_node;
   logic upd_dir;
   logic vic_dir;

   always_comb begin
      tree_out = tree_in;
      upd_node = 0;
      upd_dir  = 1'b0;
      for (int l = 0; l < WAY_W; l++) begin
         upd_dir = access_way[WAY_W-1-l];
         for (int j = 0; j < NUM_WAYS-1; j++) begin
            if (j == upd_node) tree_out[j] = ~upd_dir;
         end
         upd_node = 2*upd_node + 1 + int'(upd_dir);
      end
   end

   always_comb begin
      victim_way = '0;
      vic_node   = 0;
      vic_dir    = 1'b0;
      for (int l = 0; l < WAY_W; l++) begin
         vic_dir = 1'b0;
         for (int j = 0; j < NUM_WAYS-1; j++) begin
            if (j == vic_node) vic_dir = tree_in[j];
         end
         victim_way[WAY_W-1-l] = vic_dir;
         vic_node = 2*vic_node + 1 + int'(vic_dir);
      end
   end

endmodule

// File: rtl/ifu_icache.sv
// Set-associative instruction cache with single-line refill.
//   Clock : clock, rising edge
//   Rst   : asynchronous active-high reset
//   bus   : ifu_icache_if.slave (fetch, refill, flush, statistics)
// A hit returns the line one cycle after the request. A miss latches the
// line address in memReqAddr, refills one line and returns it from FILL.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting fetches (pcReady=1); hits answered next cycle
// MISS_REQ  | memReqValid held with a stable address until memReqReady
// MISS_WAIT | waiting for memRspValid; the line is captured on arrival
// FILL      | line returned to the core and installed unless stale
module ifu_icache
   import ifu_pkg::*;
#(
   parameter int NUM_SETS     = 4,
   parameter int NUM_WAYS     = 4,
   parameter int LINE_WIDTH   = 128,
   parameter int OFFSET_WIDTH = 4
) (
   input logic         Clock,
   input logic         Rst,
   ifu_icache_if.slave bus
);

   localparam int SET_WIDTH = $clog2(NUM_SETS);
   localparam int TAG_BITS  = 32 - OFFSET_WIDTH - SET_WIDTH;
   localparam int SET_IDX_W = (SET_WIDTH > 0) ? SET_WIDTH : 1;
   localparam int WAY_W     = $clog2(NUM_WAYS);
   localparam logic [31:0] OFFSET_MASK = 32'((64'd1 << OFFSET_WIDTH) - 64'd1);

   ifu_icache_state_t     state;
   ifu_tag_entry_t        tag_q  [NUM_SETS][NUM_WAYS];
   logic [LINE_WIDTH-1:0] data_q [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-2:0]   plru_q [NUM_SETS];
   logic                  stale_q;
   logic [LINE_WIDTH-1:0] fill_line_q;

   logic [SET_IDX_W-1:0]  req_set;
   logic [SET_IDX_W-1:0]  miss_set;
   logic [31:0]           req_tag;
   logic [31:0]           miss_tag;
   logic [NUM_WAYS-1:0]   match_vec;
   logic [WAY_W-1:0]      hit_way;
   logic                  req_fire;
   logic                  is_hit;
   logic                  install;
   logic                  inv_found;
   logic [WAY_W-1:0]      inv_way;
   logic [WAY_W-1:0]      victim_way;
   logic [SET_IDX_W-1:0]  plru_set;
   logic [WAY_W-1:0]      plru_access;
   logic [NUM_WAYS-2:0]   plru_next;
   logic [WAY_W-1:0]      plru_victim;

   // memReqAddr doubles as the latched miss address for the whole refill.
   assign req_set  = (NUM_SETS > 1) ? bus.pc[OFFSET_WIDTH +: SET_IDX_W] : '0;
   assign miss_set = (NUM_SETS > 1) ? bus.memReqAddr[OFFSET_WIDTH +: SET_IDX_W] : '0;
   assign req_tag  = 32'(bus.pc[31 -: TAG_BITS]);
   assign miss_tag = 32'(bus.memReqAddr[31 -: TAG_BITS]);

   always_comb begin
      match_vec = '0;
      hit_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         match_vec[w] = tag_q[req_set][w].valid && (tag_q[req_set][w].tag == req_tag);
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (match_vec[w]) hit_way = WAY_W'(w);
      end
   end

   // A flush in the request cycle wipes the arrays, so the request misses.
   assign req_fire = (state == IDLE) && bus.pcValid;
   assign is_hit   = req_fire && !bus.flush && (|match_vec);
   assign install  = (state == FILL) && !stale_q;

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
         if (!tag_q[miss_set][w].valid) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign victim_way  = inv_found ? inv_way : plru_victim;
   assign plru_set    = (state == FILL) ? miss_set : req_set;
   assign plru_access = (state == FILL) ? victim_way : hit_way;

   ifu_plru #(
      .NUM_WAYS (NUM_WAYS)
   ) u_plru (
      .tree_in    (plru_q[plru_set]),
      .access_way (plru_access),
      .tree_out   (plru_next),
      .victim_way (plru_victim)
   );

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state               <= IDLE;
         bus.pcReady         <= 1'b1;
         bus.insLineValidOut <= 1'b0;
         bus.memReqValid     <= 1'b0;
         bus.memReqAddr      <= '0;
         bus.hitCount        <= '0;
         bus.missCount       <= '0;
         stale_q             <= 1'b0;
      end else begin
         bus.insLineValidOut <= 1'b0;
         case (state)
            IDLE: begin
               stale_q <= 1'b0;
               if (req_fire) begin
                  if (is_hit) begin
                     bus.insLineValidOut <= 1'b1;
                     bus.hitCount        <= sat_inc(bus.hitCount);
                  end else begin
                     bus.memReqValid <= 1'b1;
                     bus.memReqAddr  <= bus.pc & ~OFFSET_MASK;
                     bus.missCount   <= sat_inc(bus.missCount);
                     bus.pcReady     <= 1'b0;
                     state           <= MISS_REQ;
                  end
               end
            end
            MISS_REQ: begin
               if (bus.flush) stale_q <= 1'b1;
               if (bus.memReqReady) begin
                  bus.memReqValid <= 1'b0;
                  state           <= MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               if (bus.flush) stale_q <= 1'b1;
               if (bus.memRspValid) begin
                  bus.insLineValidOut <= 1'b1;
                  state               <= FILL;
               end
            end
            FILL: begin
               stale_q     <= 1'b0;
               bus.pcReady <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               state       <= IDLE;
               bus.pcReady <= 1'b1;
            end
         endcase
      end
   end

   // Valid and PLRU bits; flush beats any install or PLRU touch.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) tag_q[s][w].valid <= 1'b0;
         end
      end else if (bus.flush) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) tag_q[s][w].valid <= 1'b0;
         end
      end else if (is_hit) begin
         plru_q[req_set] <= plru_next;
      end else if (install) begin
         tag_q[miss_set][victim_way].valid <= 1'b1;
         tag_q[miss_set][victim_way].tag   <= miss_tag;
         plru_q[miss_set]                  <= plru_next;
      end
   end

   always_ff @(posedge Clock) begin
      if (is_hit) begin
         bus.insLineOut <= data_q[req_set][hit_way];
      end else if ((state == MISS_WAIT) && bus.memRspValid) begin
         bus.insLineOut <= bus.memRspLine;
         fill_line_q    <= bus.memRspLine;
      end
      if (install) data_q[miss_set][victim_way] <= fill_line_q;
   end

   a_single_match: assert property (@(posedge Clock) disable iff (Rst)
      (state == IDLE && bus.pcValid) |-> $onehot0(match_vec));

endmodule

// File: tb/tb_ifu_icache.sv
module tb_ifu_icache;

   localparam int NS  = 4;
   localparam int NW  = 4;
   localparam int LW  = 128;
   localparam int LOG = 2;

   localparam int FL_NONE = 0;
   localparam int FL_IDLE = 1;
   localparam int FL_REQ  = 2;
   localparam int FL_WAIT = 3;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ifu_icache_if #(.LINE_WIDTH(LW)) bus ();

   ifu_icache #(
      .NUM_SETS     (NS),
      .NUM_WAYS     (NW),
      .LINE_WIDTH   (LW),
      .OFFSET_WIDTH (4)
   ) dut (
      .Clock (clk),
      .Rst   (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   bit          m_valid [NS][NW];
   logic [31:0] m_tag   [NS][NW];
   logic [LW-1:0] m_data [NS][NW];
   bit          m_right [NS][LOG][NW];  // 1: right half touched most recently
   int          m_hits;
   int          m_misses;

   task automatic model_flush();
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 0;
            for (int l = 0; l < LOG; l++) m_right[s][l][w] = 0;
         end
   endtask

   task automatic model_touch(input int s, input int w);
      for (int l = 0; l < LOG; l++)
         m_right[s][l][w >> (LOG-l)] = ((w >> (LOG-1-l)) & 1) == 1;
   endtask

   function automatic int model_victim(input int s);
      int v;
      v = -1;
      for (int w = NW-1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v >= 0) return v;
      v = 0;
      for (int l = 0; l < LOG; l++) v = v*2 + (m_right[s][l][v] ? 0 : 1);
      return v;
   endfunction

   task automatic model_access(input logic [31:0] a, input int fl, input logic [LW-1:0] rsp,
                               output bit exp_hit, output logic [LW-1:0] exp_line);
      int s, w;
      bit found;
      logic [31:0] t;
      s = int'((a >> 4) % NS);
      t = a >> 6;
      found = 0;
      w = 0;
      for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == t) begin found = 1; w = i; end
      if (fl == FL_IDLE) model_flush();
      exp_hit = found && (fl != FL_IDLE);
      if (exp_hit) begin
         exp_line = m_data[s][w];
         model_touch(s, w);
         m_hits++;
      end else begin
         m_misses++;
         exp_line = rsp;
         if (fl == FL_REQ || fl == FL_WAIT) model_flush();
         else begin
            w = model_victim(s);
            m_valid[s][w] = 1;
            m_tag[s][w]   = t;
            m_data[s][w]  = rsp;
            model_touch(s, w);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic reset_dut();
      rst = 1'b1;
      bus.pc = '0; bus.pcValid = 0; bus.memReqReady = 0;
      bus.memRspValid = 0; bus.memRspLine = '0; bus.flush = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_flush();
      m_hits = 0;
      m_misses = 0;
      @(negedge clk);
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic run_access(input logic [31:0] a, input int rdy_dly, input int rsp_dly,
                             input int fl, input logic [LW-1:0] rsp,
                             output bit hit, output logic [LW-1:0] line,
                             output logic [31:0] addr, output bit hold_ok, output bit proto_ok);
      proto_ok = 1; hold_ok = 1; hit = 0; line = '0; addr = '0;
      @(negedge clk);
      if (!bus.pcReady) proto_ok = 0;
      bus.pc = a; bus.pcValid = 1; bus.flush = (fl == FL_IDLE);
      @(negedge clk);
      bus.pcValid = 0; bus.flush = 0;
      if (bus.insLineValidOut) begin
         hit = 1;
         line = bus.insLineOut;
         if (bus.memReqValid) proto_ok = 0;
      end else if (bus.memReqValid) begin
         addr = bus.memReqAddr;
         if (bus.pcReady) proto_ok = 0;
         bus.flush = (fl == FL_REQ);
         for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            bus.flush = 0;
            if (!bus.memReqValid || bus.memReqAddr !== addr || bus.pcReady) hold_ok = 0;
         end
         bus.memReqReady = 1;
         @(negedge clk);
         bus.memReqReady = 0;
         bus.flush = (fl == FL_WAIT);
         if (bus.memReqValid) proto_ok = 0;
         for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            bus.flush = 0;
            if (bus.insLineValidOut || bus.pcReady) proto_ok = 0;
         end
         bus.memRspValid = 1; bus.memRspLine = rsp;
         @(negedge clk);
         bus.memRspValid = 0; bus.flush = 0;
         if (!bus.insLineValidOut) proto_ok = 0;
         line = bus.insLineOut;
      end else begin
         proto_ok = 0;
      end
      @(negedge clk);
      if (bus.insLineValidOut || !bus.pcReady) proto_ok = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_dut();
      checks++;
      if (bus.pcReady !== 1'b1 || bus.insLineValidOut !== 1'b0 || bus.memReqValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got pcReady=%b valid=%b memReq=%b, want 1 0 0",
                  bus.pcReady, bus.insLineValidOut, bus.memReqValid);
      end
      checks++;
      if (bus.hitCount !== 32'd0 || bus.missCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got hit=%0d miss=%0d, want 0 0", bus.hitCount, bus.missCount);
      end
   endtask

   logic [LW-1:0] line_a;

   task automatic test_cold_miss();
      bit hit, hold_ok, proto_ok, eh;
      logic [LW-1:0] line, el;
      logic [31:0] addr;
      line_a = rand_line();
      model_access(32'h100, FL_NONE, line_a, eh, el);
      run_access(32'h100, 0, 1, FL_NONE, line_a, hit, line, addr, hold_ok, proto_ok);
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL cold_is_miss: got hit=%b want 0", hit); end
      checks++;
      if (addr !== 32'h100) begin errors++; $display("FAIL cold_addr: got %h want 00000100", addr); end
      checks++;
      if (line !== line_a) begin errors++; $display("FAIL cold_line: got %h want %h", line, line_a); end
      checks++;
      if (!proto_ok) begin errors++; $display("FAIL cold_protocol: got bad handshake/pulse, want single pulse"); end
      checks++;
      if (bus.missCount !== 32'd1 || bus.hitCount !== 32'd0) begin
         errors++; $display("FAIL cold_counts: got hit=%0d miss=%0d want 0 1", bus.hitCount, bus.missCount);
      end
   endtask

   task automatic test_hit();
      bit hit, hold_ok, proto_ok, eh;
      logic [LW-1:0] line, el;
      logic [31:0] addr;
      model_access(32'h100, FL_NONE, '0, eh, el);
      run_access(32'h100, 0, 0, FL_NONE, '0, hit, line, addr, hold_ok, proto_ok);
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL hit_detect: got hit=%b want 1", hit); end
      checks++;
      if (line !== line_a) begin errors++; $display("FAIL hit_line: got %h want %h", line, line_a); end
      checks++;
      if (!proto_ok) begin errors++; $display("FAIL hit_protocol: got memReq or extra pulse, want none"); end
      checks++;
      if (bus.hitCount !== 32'd1) begin errors++; $display("FAIL hit_count: got %0d want 1", bus.hitCount); end
   endtask

   // All tags map to set 0 (pc = tag << 6). Touch order 2,0,1 leaves the
   // tree pointing at way 3.
   task automatic test_eviction();
      bit hit, hold_ok, proto_ok, eh;
      logic [LW-1:0] line, el, rsp;
      logic [31:0] addr;
      int seq [9] = '{0, 1, 2, 3, 2, 0, 1, 4, 0};
      reset_dut();
      foreach (seq[i]) begin
         rsp = rand_line();
         model_access(32'(seq[i]) << 6, FL_NONE, rsp, eh, el);
         run_access(32'(seq[i]) << 6, 0, 0, FL_NONE, rsp, hit, line, addr, hold_ok, proto_ok);
         checks++;
         if (hit !== eh || line !== el || !proto_ok) begin
            errors++;
            $display("FAIL evict_step%0d: got hit=%b line=%h ok=%b want hit=%b line=%h", i, hit, line, proto_ok, eh, el);
         end
      end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL evict_tag0_kept: got hit=%b want 1", hit); end
      rsp = rand_line();
      model_access(32'h0C0, FL_NONE, rsp, eh, el);
      run_access(32'h0C0, 0, 0, FL_NONE, rsp, hit, line, addr, hold_ok, proto_ok);
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL evict_way3_replaced: got hit=%b want 0", hit); end
   endtask

   task automatic test_backpressure();
      bit hit, hold_ok, proto_ok, eh;
      logic [LW-1:0] line, el, rsp;
      logic [31:0] addr;
      rsp = rand_line();
      model_access(32'h347, FL_NONE, rsp, eh, el);
      run_access(32'h347, 5, 2, FL_NONE, rsp, hit, line, addr, hold_ok, proto_ok);
      checks++;
      if (!hold_ok) begin errors++; $display("FAIL bp_hold: got unstable req or pcReady, want held"); end
      checks++;
      if (addr !== 32'h340) begin errors++; $display("FAIL bp_addr: got %h want 00000340", addr); end
      checks++;
      if (line !== el || !proto_ok) begin errors++; $display("FAIL bp_line: got %h want %h", line, el); end
   endtask

   task automatic test_flush_wait();
      bit hit, hold_ok, proto_ok, eh;
      logic [LW-1:0] line, el, rsp;
      logic [31:0] addr;
      logic [31:0] pcs [5] = '{32'h500, 32'h510, 32'h620, 32'h620, 32'h500};
      int fls [5] = '{FL_NONE, FL_NONE, FL_WAIT, FL_NONE, FL_NONE};
      foreach (pcs[i]) begin
         rsp = rand_line();
         model_access(pcs[i], fls[i], rsp, eh, el);
         run_access(pcs[i], 1, 1, fls[i], rsp, hit, line, addr, hold_ok, proto_ok);
         checks++;
         if (hit !== eh || line !== el || !proto_ok) begin
            errors++;
            $display("FAIL flush_step%0d: got hit=%b line=%h ok=%b want hit=%b line=%h", i, hit, line, proto_ok, eh, el);
         end
         if (i >= 3) begin
            checks++;
            if (hit !== 1'b0) begin errors++; $display("FAIL flush_miss_after%0d: got hit=%b want 0", i, hit); end
         end
      end
   endtask

   task automatic test_reset_mid_miss();
      bit seen;
      reset_dut();
      @(negedge clk);
      bus.pc = 32'h200; bus.pcValid = 1;
      @(negedge clk);
      bus.pcValid = 0; bus.memReqReady = 1;
      @(negedge clk);
      bus.memReqReady = 0;
      checks++;
      if (bus.pcReady !== 1'b0 || bus.missCount !== 32'd1) begin
         errors++; $display("FAIL midmiss_pre: got pcReady=%b miss=%0d want 0 1", bus.pcReady, bus.missCount);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.pcReady !== 1'b1 || bus.memReqValid !== 1'b0) begin
         errors++; $display("FAIL midmiss_async: got pcReady=%b memReq=%b want 1 0", bus.pcReady, bus.memReqValid);
      end
      @(negedge clk);
      rst = 1'b0;
      model_flush(); m_hits = 0; m_misses = 0;
      bus.memRspValid = 1; bus.memRspLine = rand_line();
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.memRspValid = 0;
         if (bus.insLineValidOut) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL midmiss_late_rsp: got insLineValidOut=1 want 0"); end
      checks++;
      if (bus.pcReady !== 1'b1 || bus.hitCount !== 32'd0 || bus.missCount !== 32'd0) begin
         errors++; $display("FAIL midmiss_state: got pcReady=%b hit=%0d miss=%0d want 1 0 0",
                            bus.pcReady, bus.hitCount, bus.missCount);
      end
   endtask

   task automatic test_random();
      bit hit, hold_ok, proto_ok, eh;
      logic [LW-1:0] line, el, rsp;
      logic [31:0] addr, a;
      int fl, r;
      for (int n = 0; n < 150; n++) begin
         a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
         r = $urandom_range(0, 19);
         fl = (r == 0) ? FL_IDLE : (r == 1) ? FL_REQ : (r == 2) ? FL_WAIT : FL_NONE;
         rsp = rand_line();
         model_access(a, fl, rsp, eh, el);
         run_access(a, $urandom_range(0, 3), $urandom_range(0, 3), fl, rsp, hit, line, addr, hold_ok, proto_ok);
         checks++;
         if (hit !== eh || line !== el) begin
            errors++;
            $display("FAIL rand%0d_data: pc=%h got hit=%b line=%h want hit=%b line=%h", n, a, hit, line, eh, el);
         end
         checks++;
         if (!proto_ok || !hold_ok || (!eh && addr !== (a & 32'hFFFF_FFF0))) begin
            errors++;
            $display("FAIL rand%0d_proto: got ok=%b hold=%b addr=%h want 1 1 %h", n, proto_ok, hold_ok, addr, a & 32'hFFFF_FFF0);
         end
         checks++;
         if (bus.hitCount !== 32'(m_hits) || bus.missCount !== 32'(m_misses)) begin
            errors++;
            $display("FAIL rand%0d_counts: got hit=%0d miss=%0d want %0d %0d", n, bus.hitCount, bus.missCount, m_hits, m_misses);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      test_reset();
      test_cold_miss();
      test_hit();
      test_backpressure();
      test_flush_wait();
      test_eviction();
      test_reset_mid_miss();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
